// File: rtl/router_port_receiver.sv
// router_port_receiver: drains one router output FIFO, parses header/payload/parity,
// flags parity and address errors, counts packets and aborts stalled packets.
module router_port_receiver #(
    parameter int         READ_DELAY = 0,
    parameter int         TIMEOUT    = 31,
    parameter logic [1:0] PORT_ADDR  = 2'b00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        vld_out,
    input  logic [7:0]  data_out,
    output logic        read_enb,
    output logic [7:0]  rx_data,
    output logic        rx_data_valid,
    output logic [5:0]  rx_len,
    output logic [1:0]  rx_addr,
    output logic        pkt_done,
    output logic        parity_err,
    output logic        addr_err,
    output logic        pkt_abort,
    output logic [15:0] pkt_count,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, DELAY, HDR_RD, HDR_WAIT, BODY, DONE} state_t;

    localparam logic [4:0] DLY_LAST = 5'(READ_DELAY - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [4:0]  dly_q;
    logic [7:0]  to_q, to_d;
    logic [6:0]  iss_q, cap_q;
    logic        pend_q;
    logic [7:0]  par_q;
    logic [7:0]  rx_data_q;
    logic        rx_data_valid_q;
    logic [5:0]  rx_len_q;
    logic [1:0]  rx_addr_q;
    logic        pkt_done_q, parity_err_q, addr_err_q, pkt_abort_q;
    logic [15:0] pkt_count_q;
    logic        body_rd, timeout, last_cap;

    // body reads cover the payload plus the trailing parity byte
    assign body_rd  = (state_q == BODY) && vld_out && (iss_q < {1'b0, rx_len_q} + 7'd1);
    assign read_enb = (state_q == HDR_RD) || body_rd;
    assign busy     = state_q != IDLE;
    assign to_d     = vld_out ? 8'd0 : to_q + 8'd1;
    assign timeout  = !vld_out && (to_q == TO_LAST);
    assign last_cap = pend_q && (cap_q == {1'b0, rx_len_q});

    assign rx_data       = rx_data_q;
    assign rx_data_valid = rx_data_valid_q;
    assign rx_len        = rx_len_q;
    assign rx_addr       = rx_addr_q;
    assign pkt_done      = pkt_done_q;
    assign parity_err    = parity_err_q;
    assign addr_err      = addr_err_q;
    assign pkt_abort     = pkt_abort_q;
    assign pkt_count     = pkt_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            dly_q           <= '0;
            to_q            <= '0;
            iss_q           <= '0;
            cap_q           <= '0;
            pend_q          <= 1'b0;
            par_q           <= '0;
            rx_data_q       <= '0;
            rx_data_valid_q <= 1'b0;
            rx_len_q        <= '0;
            rx_addr_q       <= '0;
            pkt_done_q      <= 1'b0;
            parity_err_q    <= 1'b0;
            addr_err_q      <= 1'b0;
            pkt_abort_q     <= 1'b0;
            pkt_count_q     <= '0;
        end else begin
            rx_data_valid_q <= 1'b0;
            pkt_done_q      <= 1'b0;
            pkt_abort_q     <= 1'b0;
            pend_q          <= body_rd;
            case (state_q)
                IDLE: if (vld_out && enable) begin
                    dly_q   <= '0;
                    state_q <= (READ_DELAY == 0) ? HDR_RD : DELAY;
                end
                DELAY: begin
                    dly_q   <= dly_q + 5'd1;
                    state_q <= (dly_q == DLY_LAST) ? HDR_RD : DELAY;
                end
                HDR_RD: begin
                    to_q    <= '0;
                    state_q <= HDR_WAIT;
                end
                HDR_WAIT: begin
                    to_q <= to_d;
                    if (timeout) begin
                        pkt_abort_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        rx_len_q     <= data_out[7:2];
                        rx_addr_q    <= data_out[1:0];
                        par_q        <= data_out;
                        parity_err_q <= 1'b0;
                        addr_err_q   <= 1'b0;
                        iss_q        <= '0;
                        cap_q        <= '0;
                        state_q      <= BODY;
                    end
                end
                BODY: begin
                    to_q <= to_d;
                    if (body_rd) iss_q <= iss_q + 7'd1;
                    // a completing parity capture wins over a simultaneous timeout
                    if (last_cap) begin
                        parity_err_q <= data_out != par_q;
                        addr_err_q   <= rx_addr_q != PORT_ADDR;
                        pkt_done_q   <= 1'b1;
                        pkt_count_q  <= pkt_count_q + 16'd1;
                        state_q      <= DONE;
                    end else begin
                        if (pend_q) begin
                            rx_data_q       <= data_out;
                            rx_data_valid_q <= 1'b1;
                            par_q           <= par_q ^ data_out;
                            cap_q           <= cap_q + 7'd1;
                        end
                        if (timeout) begin
                            pkt_abort_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_router_port_receiver.sv
// tb_router_port_receiver: directed scenarios against a registered-read FIFO model,
// with three receiver instances sharing the FIFO (default, PORT_ADDR=2, READ_DELAY=10).
module tb_router_port_receiver;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        vld_out = 1'b0;
    logic [7:0]  data_out = 8'h00;
    logic [2:0]  en = 3'b000;
    logic        re [3];
    logic        dv [3];
    logic        done [3];
    logic        perr [3];
    logic        aerr [3];
    logic        abrt [3];
    logic        bsy [3];
    logic [7:0]  rxd [3];
    logic [5:0]  len [3];
    logic [1:0]  addr [3];
    logic [15:0] cnt [3];

    logic [7:0] q [$];
    logic [7:0] exp_q [$];
    logic [7:0] got [$];
    int sel = 0;
    int cyc = 0;
    int n_valid, n_done, n_abort, t_rise, t_drop, t_re, t_abort;
    logic re_s = 1'b0;
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    router_port_receiver u0 (
        .clock(clock), .reset(reset), .enable(en[0]), .vld_out(vld_out), .data_out(data_out),
        .read_enb(re[0]), .rx_data(rxd[0]), .rx_data_valid(dv[0]), .rx_len(len[0]),
        .rx_addr(addr[0]), .pkt_done(done[0]), .parity_err(perr[0]), .addr_err(aerr[0]),
        .pkt_abort(abrt[0]), .pkt_count(cnt[0]), .busy(bsy[0]));

    router_port_receiver #(.PORT_ADDR(2'b10)) u2 (
        .clock(clock), .reset(reset), .enable(en[1]), .vld_out(vld_out), .data_out(data_out),
        .read_enb(re[1]), .rx_data(rxd[1]), .rx_data_valid(dv[1]), .rx_len(len[1]),
        .rx_addr(addr[1]), .pkt_done(done[1]), .parity_err(perr[1]), .addr_err(aerr[1]),
        .pkt_abort(abrt[1]), .pkt_count(cnt[1]), .busy(bsy[1]));

    router_port_receiver #(.READ_DELAY(10)) ud (
        .clock(clock), .reset(reset), .enable(en[2]), .vld_out(vld_out), .data_out(data_out),
        .read_enb(re[2]), .rx_data(rxd[2]), .rx_data_valid(dv[2]), .rx_len(len[2]),
        .rx_addr(addr[2]), .pkt_done(done[2]), .parity_err(perr[2]), .addr_err(aerr[2]),
        .pkt_abort(abrt[2]), .pkt_count(cnt[2]), .busy(bsy[2]));

    task automatic tick();
        logic v;
        @(posedge clock);
        cyc++;
        #1;
        if (re_s && q.size() > 0) data_out = q.pop_front();
        v = q.size() > 0;
        if (v && !vld_out) t_rise = cyc;
        if (!v && vld_out) t_drop = cyc;
        vld_out = v;
        @(negedge clock);
        re_s = re[0] | re[1] | re[2];
        if (re[sel] && t_re < 0) t_re = cyc;
        if (dv[sel]) begin n_valid++; got.push_back(rxd[sel]); end
        if (done[sel]) n_done++;
        if (abrt[sel]) begin n_abort++; t_abort = cyc; end
    endtask

    task automatic clear();
        n_valid = 0; n_done = 0; n_abort = 0;
        t_rise = -1; t_drop = -1; t_re = -1; t_abort = -1;
        got.delete();
        exp_q.delete();
    endtask

    task automatic push_pkt(input logic [7:0] hdr, input logic [7:0] flip);
        logic [7:0] par, b;
        par = hdr;
        q.push_back(hdr);
        for (int i = 0; i < int'(hdr[7:2]); i++) begin
            b = 8'(i * 37 + 11) ^ hdr;
            q.push_back(b);
            exp_q.push_back(b);
            par ^= b;
        end
        q.push_back(par ^ flip);
    endtask

    task automatic run(input int want, input int budget);
        int k;
        k = 0;
        while (n_done < want && n_abort == 0 && k < budget) begin tick(); k++; end
        checks++;
        if (n_done < want && n_abort == 0) begin
            errors++;
            $display("FAIL run_budget: pkt_done=%0d after %0d cycles, required %0d", n_done, k, want);
        end
    endtask

    task automatic check_payload(input string name);
        int bad;
        bad = (got.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) if (got[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_payload: %0d bad bytes, got %0d bytes, required %0d", name, bad, got.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({re[i], dv[i], rxd[i], len[i], addr[i], done[i], perr[i], aerr[i], abrt[i], cnt[i], bsy[i]} !== 39'd0) begin
                errors++;
                $display("FAIL reset_outputs: inst %0d outputs=%h required 0", i,
                         {re[i], dv[i], rxd[i], len[i], addr[i], done[i], perr[i], aerr[i], abrt[i], cnt[i], bsy[i]});
            end
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_good();
        sel = 0; en = 3'b001;
        clear();
        push_pkt(8'h38, 8'h00);
        run(1, 200);
        check_payload("good");
        checks++; if (n_valid !== 14) begin errors++; $display("FAIL good_valid: got %0d required 14", n_valid); end
        checks++; if (perr[0] !== 1'b0) begin errors++; $display("FAIL good_parity_err: got %b required 0", perr[0]); end
        checks++; if (aerr[0] !== 1'b0) begin errors++; $display("FAIL good_addr_err: got %b required 0", aerr[0]); end
        checks++; if (cnt[0] !== 16'd1) begin errors++; $display("FAIL good_count: got %0d required 1", cnt[0]); end
        checks++; if (len[0] !== 6'd14 || addr[0] !== 2'd0) begin errors++; $display("FAIL good_hdr: len=%0d addr=%0d required 14/0", len[0], addr[0]); end
        repeat (3) tick();
        checks++; if (n_done !== 1) begin errors++; $display("FAIL good_done_once: got %0d required 1", n_done); end
        checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL good_idle: busy=%b required 0", bsy[0]); end
    endtask

    task automatic test_timeout();
        sel = 0; en = 3'b001;
        clear();
        q.push_back(8'h38);
        for (int i = 0; i < 5; i++) q.push_back(8'(i + 1));
        run(1, 100);
        checks++; if (n_abort !== 1) begin errors++; $display("FAIL timeout_abort: got %0d pulses required 1", n_abort); end
        checks++; if (t_abort - t_drop !== 31) begin errors++; $display("FAIL timeout_latency: got %0d cycles required 31", t_abort - t_drop); end
        checks++; if (n_valid !== 5 || n_done !== 0) begin errors++; $display("FAIL timeout_partial: valid=%0d done=%0d required 5/0", n_valid, n_done); end
        checks++; if (cnt[0] !== 16'd1 || perr[0] !== 1'b0 || aerr[0] !== 1'b0) begin errors++; $display("FAIL timeout_state: count=%0d perr=%b aerr=%b required 1/0/0", cnt[0], perr[0], aerr[0]); end
        tick();
        checks++; if (bsy[0] !== 1'b0 || abrt[0] !== 1'b0) begin errors++; $display("FAIL timeout_idle: busy=%b abort=%b required 0/0", bsy[0], abrt[0]); end
    endtask

    task automatic test_len0();
        sel = 0; en = 3'b001;
        clear();
        push_pkt(8'h01, 8'h00);
        run(1, 50);
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL len0_valid: got %0d required 0", n_valid); end
        checks++; if (aerr[0] !== 1'b1 || perr[0] !== 1'b0) begin errors++; $display("FAIL len0_flags: aerr=%b perr=%b required 1/0", aerr[0], perr[0]); end
        checks++; if (cnt[0] !== 16'd2 || len[0] !== 6'd0 || addr[0] !== 2'd1) begin errors++; $display("FAIL len0_state: count=%0d len=%0d addr=%0d required 2/0/1", cnt[0], len[0], addr[0]); end
        repeat (2) tick();
    endtask

    task automatic test_parity();
        sel = 1; en = 3'b010;
        clear();
        push_pkt(8'h42, 8'h01);
        run(1, 200);
        check_payload("parity");
        checks++; if (perr[1] !== 1'b1 || aerr[1] !== 1'b0) begin errors++; $display("FAIL parity_flags: perr=%b aerr=%b required 1/0", perr[1], aerr[1]); end
        checks++; if (len[1] !== 6'd16 || cnt[1] !== 16'd1) begin errors++; $display("FAIL parity_state: len=%0d count=%0d required 16/1", len[1], cnt[1]); end
        repeat (2) tick();
    endtask

    task automatic test_delay();
        sel = 2; en = 3'b100;
        clear();
        push_pkt(8'h38, 8'h00);
        run(1, 200);
        checks++; if (t_re - t_rise !== 11) begin errors++; $display("FAIL delay_first_read: got %0d cycles required 11", t_re - t_rise); end
        checks++; if (perr[2] !== 1'b0 || cnt[2] !== 16'd1) begin errors++; $display("FAIL delay_done: perr=%b count=%0d required 0/1", perr[2], cnt[2]); end
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        sel = 0; en = 3'b001;
        clear();
        push_pkt(8'h38, 8'h00);
        push_pkt(8'h0C, 8'h00);
        run(2, 400);
        check_payload("b2b");
        checks++; if (n_valid !== 17) begin errors++; $display("FAIL b2b_valid: got %0d required 17", n_valid); end
        checks++; if (cnt[0] !== 16'd4 || perr[0] !== 1'b0 || aerr[0] !== 1'b0) begin errors++; $display("FAIL b2b_state: count=%0d perr=%b aerr=%b required 4/0/0", cnt[0], perr[0], aerr[0]); end
        checks++; if (len[0] !== 6'd3) begin errors++; $display("FAIL b2b_len: got %0d required 3", len[0]); end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        int k;
        sel = 0; en = 3'b001;
        clear();
        push_pkt(8'h38, 8'h00);
        k = 0;
        while (n_valid < 3 && k < 100) begin tick(); k++; end
        checks++; if (n_valid !== 3 || bsy[0] !== 1'b1) begin errors++; $display("FAIL rstmid_body: valid=%0d busy=%b required 3/1", n_valid, bsy[0]); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({re[0], dv[0], rxd[0], len[0], addr[0], done[0], perr[0], aerr[0], abrt[0], cnt[0], bsy[0]} !== 39'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: outputs=%h required 0",
                     {re[0], dv[0], rxd[0], len[0], addr[0], done[0], perr[0], aerr[0], abrt[0], cnt[0], bsy[0]});
        end
        repeat (2) @(posedge clock);
        q.delete();
        vld_out = 1'b0;
        re_s = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        clear();
        push_pkt(8'h38, 8'h00);
        run(1, 200);
        check_payload("rstmid");
        checks++; if (cnt[0] !== 16'd1 || perr[0] !== 1'b0 || n_abort !== 0) begin errors++; $display("FAIL rstmid_resume: count=%0d perr=%b abort=%0d required 1/0/0", cnt[0], perr[0], n_abort); end
    endtask

    initial begin
        test_reset();
        test_good();
        test_timeout();
        test_len0();
        test_parity();
        test_delay();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
